// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
// Owns the RTC multiplexed address/data bus. It arbitrates between the
// periodic read-refresh sequencer and the user-edit write path, and runs each
// grant as one Intel-style cycle. The cycle has an address phase, a gap, a
// data phase and a second gap, and every phase lasts T_PHASE clocks. Every
// output comes from a register: the next-state logic computes the values the
// outputs will take, and the state register stores them.
module rtc_bus_arbiter #(
    parameter int T_PHASE = 6,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_done,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_done,
    output logic       busy,
    inout  wire  [7:0] dato,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_GAP,
        S_DATA,
        S_DATA_GAP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(T_PHASE - 1);
    localparam logic [CNT_W-1:0] STB_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(T_PHASE - 2);
    localparam logic             GRANT_RD  = 1'b0;
    localparam logic             GRANT_WR  = 1'b1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_grant_reg, last_grant_next;
    logic [7:0]       addr_reg, addr_next;
    logic [7:0]       data_reg, data_next;
    logic             is_write_reg, is_write_next;

    logic             busy_reg, busy_next;
    logic             wr_done_reg, wr_done_next;
    logic             rd_done_reg, rd_done_next;
    logic [7:0]       rd_data_reg, rd_data_next;
    logic             cs_reg, cs_next;
    logic             rd_reg, rd_next;
    logic             wr_reg, wr_next;
    logic             a_d_reg, a_d_next;
    logic [7:0]       dout_reg, dout_next;
    logic             oe_reg, oe_next;
    logic             strobe_on;

    // Next-state logic. It covers arbitration, phase sequencing and the
    // registered bus outputs, which are decoded from the next state.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        is_write_next   = is_write_reg;
        rd_data_next    = rd_data_reg;

        unique case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                // When both requesters are pending, the one opposite the last grant wins.
                if (wr_req && (!rd_req || last_grant_reg == GRANT_RD)) begin
                    state_next      = S_ADDR;
                    addr_next       = wr_addr;
                    data_next       = wr_data;
                    is_write_next   = 1'b1;
                    last_grant_next = GRANT_WR;
                end else if (rd_req) begin
                    state_next      = S_ADDR;
                    addr_next       = rd_addr;
                    is_write_next   = 1'b0;
                    last_grant_next = GRANT_RD;
                end
            end
            S_ADDR, S_ADDR_GAP, S_DATA, S_DATA_GAP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    unique case (state_reg)
                        S_ADDR:     state_next = S_ADDR_GAP;
                        S_ADDR_GAP: state_next = S_DATA;
                        S_DATA:     state_next = S_DATA_GAP;
                        default:    state_next = S_DONE;
                    endcase
                end else begin
                    cnt_next = cnt_reg + STB_FIRST;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Sample the RTC on the last edge of the read strobe. The strobe is still low then.
        if (state_reg == S_DATA && !is_write_reg && cnt_reg == STB_LAST) begin
            rd_data_next = dato;
        end

        // Each strobe stays off for one cycle at the start and one at the end of its phase.
        // This gives setup and hold around the low period.
        strobe_on = (cnt_next >= STB_FIRST) && (cnt_next <= STB_LAST);

        cs_next      = 1'b1;
        rd_next      = 1'b1;
        wr_next      = 1'b1;
        a_d_next     = 1'b1;
        oe_next      = 1'b0;
        dout_next    = dout_reg;
        busy_next    = (state_next != S_IDLE);
        wr_done_next = (state_next == S_DONE) && is_write_next;
        rd_done_next = (state_next == S_DONE) && !is_write_next;

        unique case (state_next)
            S_ADDR: begin
                a_d_next  = 1'b0;
                oe_next   = 1'b1;
                dout_next = addr_next;
                cs_next   = !strobe_on;
                wr_next   = !strobe_on;
            end
            S_DATA: begin
                if (is_write_next) begin
                    oe_next   = 1'b1;
                    dout_next = data_next;
                    cs_next   = !strobe_on;
                    wr_next   = !strobe_on;
                end else begin
                    cs_next   = !strobe_on;
                    rd_next   = !strobe_on;
                end
            end
            default: begin
            end
        endcase
    end

    // State, latch and output registers. Reset releases the bus at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= GRANT_RD;
            addr_reg       <= 8'h00;
            data_reg       <= 8'h00;
            is_write_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            wr_done_reg    <= 1'b0;
            rd_done_reg    <= 1'b0;
            rd_data_reg    <= 8'h00;
            cs_reg         <= 1'b1;
            rd_reg         <= 1'b1;
            wr_reg         <= 1'b1;
            a_d_reg        <= 1'b1;
            dout_reg       <= 8'h00;
            oe_reg         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            is_write_reg   <= is_write_next;
            busy_reg       <= busy_next;
            wr_done_reg    <= wr_done_next;
            rd_done_reg    <= rd_done_next;
            rd_data_reg    <= rd_data_next;
            cs_reg         <= cs_next;
            rd_reg         <= rd_next;
            wr_reg         <= wr_next;
            a_d_reg        <= a_d_next;
            dout_reg       <= dout_next;
            oe_reg         <= oe_next;
        end
    end

    // Per-bit tristate driver. oe_reg is never set while the read strobe is low.
    for (genvar gi = 0; gi < 8; gi++) begin : g_dato
        assign dato[gi] = oe_reg ? dout_reg[gi] : 1'bz;
    end

    assign busy    = busy_reg;
    assign wr_done = wr_done_reg;
    assign rd_done = rd_done_reg;
    assign rd_data = rd_data_reg;
    assign cs      = cs_reg;
    assign rd      = rd_reg;
    assign wr      = wr_reg;
    assign a_d     = a_d_reg;

endmodule
